// File: rtl/debounce_switch_bank.sv
// Switch-bank debouncer: synchronizes raw switch inputs, qualifies each level
// change over DEBOUNCE_LIMIT consecutive stable cycles, and emits clean levels,
// one-cycle rise/fall pulses and a derived enable/select pair for the blinkers
// and the LED output mux.
module debounce_switch_bank #(
   parameter int NUM_SWITCHES   = 4,
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic                            i_Clk,
   input  logic                            i_Rst,
   input  logic [NUM_SWITCHES-1:0]         i_Switch,
   output logic [NUM_SWITCHES-1:0]         o_Switch,
   output logic [NUM_SWITCHES-1:0]         o_Rise,
   output logic [NUM_SWITCHES-1:0]         o_Fall,
   output logic                            o_Enable,
   output logic [$clog2(NUM_SWITCHES)-1:0] o_Select
);

   localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
   localparam int SEL_W = $clog2(NUM_SWITCHES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

   logic [NUM_SWITCHES-1:0] sync_1;
   logic [NUM_SWITCHES-1:0] sync_2;
   logic [CNT_W-1:0]        cnt [NUM_SWITCHES];

   // Two-flop synchronizer on every raw switch input.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= i_Switch;
         sync_2 <= sync_1;
      end
   end

   // Per-channel qualification: any agreement with the accepted level restarts
   // the count; the terminal count accepts the new level and fires one pulse.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Switch <= '0;
         o_Rise   <= '0;
         o_Fall   <= '0;
         for (int k = 0; k < NUM_SWITCHES; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         o_Rise <= '0;
         o_Fall <= '0;
         for (int k = 0; k < NUM_SWITCHES; k++) begin
            if (sync_2[k] == o_Switch[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == CNT_MAX) begin
               cnt[k]      <= '0;
               o_Switch[k] <= sync_2[k];
               o_Rise[k]   <= sync_2[k];
               o_Fall[k]   <= ~sync_2[k];
            end else begin
               cnt[k] <= cnt[k] + 1'b1;
            end
         end
      end
   end

   assign o_Enable = |o_Switch;

   // Fixed-priority encoder: scanning downward lets bit 0 win last.
   always_comb begin
      o_Select = '0;
      for (int k = NUM_SWITCHES - 1; k >= 0; k--) begin
         if (o_Switch[k]) begin
            o_Select = SEL_W'(k);
         end
      end
   end

endmodule

// File: tb/tb_debounce_switch_bank.sv
// Bench for debounce_switch_bank: directed scenarios plus randomized switch
// activity, checked every cycle against a sliding-window reference model.
module tb_debounce_switch_bank;

   localparam int NSW   = 4;
   localparam int LIMIT = 4;

   logic           i_Clk = 1'b0;
   logic           i_Rst;
   logic [NSW-1:0] i_Switch;
   logic [NSW-1:0] o_Switch;
   logic [NSW-1:0] o_Rise;
   logic [NSW-1:0] o_Fall;
   logic           o_Enable;
   logic [1:0]     o_Select;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a level is accepted once the synchronized input has
   // disagreed with the accepted level for LIMIT consecutive evaluations.
   logic [NSW-1:0] raw_q [$];
   logic [NSW-1:0] m_sw, m_rise, m_fall;

   debounce_switch_bank #(.NUM_SWITCHES(NSW), .DEBOUNCE_LIMIT(LIMIT)) dut (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .i_Switch (i_Switch),
      .o_Switch (o_Switch),
      .o_Rise   (o_Rise),
      .o_Fall   (o_Fall),
      .o_Enable (o_Enable),
      .o_Select (o_Select)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      raw_q.delete();
      for (int i = 0; i <= LIMIT; i++) raw_q.push_front('0);
      m_sw   = '0;
      m_rise = '0;
      m_fall = '0;
   endtask

   // raw_q[0] holds the raw value captured one edge ago; the value seen at the
   // synchronizer output during this edge's evaluation is raw_q[1].
   task automatic model_edge(input logic [NSW-1:0] v);
      logic [NSW-1:0] nsw;
      logic [NSW-1:0] smp;
      bit all_diff;
      nsw = m_sw;
      for (int ch = 0; ch < NSW; ch++) begin
         all_diff = 1'b1;
         for (int i = 1; i <= LIMIT; i++) begin
            smp = raw_q[i];
            if (smp[ch] == m_sw[ch]) all_diff = 1'b0;
         end
         if (all_diff) nsw[ch] = ~m_sw[ch];
      end
      m_rise = nsw & ~m_sw;
      m_fall = ~nsw & m_sw;
      m_sw   = nsw;
      raw_q.push_front(v);
      void'(raw_q.pop_back());
   endtask

   function automatic logic [1:0] model_sel(input logic [NSW-1:0] sw);
      for (int k = 0; k < NSW; k++) begin
         if (sw[k]) return 2'(k);
      end
      return 2'd0;
   endfunction

   task automatic check_model();
      chk("sw",  o_Switch, m_sw);
      chk("rise", o_Rise,  m_rise);
      chk("fall", o_Fall,  m_fall);
      chk("en",  o_Enable, |m_sw);
      chk("sel", o_Select, model_sel(m_sw));
   endtask

   task automatic step(input logic [NSW-1:0] v);
      i_Switch = v;
      @(posedge i_Clk);
      model_edge(v);
      #1;
      check_model();
   endtask

   task automatic check_all_zero(input string tag);
      chk(tag, {o_Switch, o_Rise, o_Fall, o_Enable, o_Select}, '0);
   endtask

   int hold_left [NSW];
   logic [NSW-1:0] rv;
   logic [NSW-1:0] bounce_pulses;

   initial begin
      i_Rst    = 1'b1;
      i_Switch = '0;
      model_reset();
      #2;
      check_all_zero("reset_hold");
      repeat (2) @(posedge i_Clk);
      #1 i_Rst = 1'b0;
      check_all_zero("reset_release");

      // Reset idle
      for (int i = 0; i < 20; i++) begin
         step(4'b0000);
         check_all_zero("idle");
      end

      // Clean rise on bit 1: edge 0 is the first step driving the new level
      for (int e = 0; e <= 4; e++) step(4'b0010);
      chk("rise1_e4_sw", o_Switch, 4'b0000);
      step(4'b0010);
      chk("rise1_e5_sw", o_Switch, 4'b0010);
      chk("rise1_e5_rise", o_Rise, 4'b0010);
      chk("rise1_e5_fall", o_Fall, 4'b0000);
      chk("rise1_e5_en", o_Enable, 1'b1);
      chk("rise1_e5_sel", o_Select, 2'd1);
      step(4'b0010);
      chk("rise1_e6_rise", o_Rise, 4'b0000);

      // Bounce rejection on bit 0
      bounce_pulses = '0;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 3; i++) begin
            step(4'b0011);
            bounce_pulses |= o_Rise | o_Fall;
         end
         for (int i = 0; i < 2; i++) begin
            step(4'b0010);
            bounce_pulses |= o_Rise | o_Fall;
         end
      end
      chk("bounce_sw0", o_Switch[0], 1'b0);
      chk("bounce_pulses", bounce_pulses, 4'b0000);
      for (int e = 0; e <= 4; e++) step(4'b0011);
      chk("bounce_e4_sw", o_Switch, 4'b0010);
      step(4'b0011);
      chk("bounce_e5_rise", o_Rise, 4'b0001);
      chk("bounce_e5_sel", o_Select, 2'd0);

      // Priority and fall
      for (int e = 0; e <= 5; e++) step(4'b1100);
      chk("prio_sw", o_Switch, 4'b1100);
      chk("prio_sel", o_Select, 2'd2);
      for (int e = 0; e <= 4; e++) step(4'b1000);
      step(4'b1000);
      chk("fall2_e5_fall", o_Fall, 4'b0100);
      chk("fall2_e5_sel", o_Select, 2'd3);
      chk("fall2_e5_en", o_Enable, 1'b1);
      step(4'b1000);
      chk("fall2_e6_fall", o_Fall, 4'b0000);

      // Reset mid-count on bit 3 (with bit 0 accepted beforehand)
      for (int i = 0; i < 8; i++) step(4'b0001);
      chk("pre_mid_sw", o_Switch, 4'b0001);
      for (int e = 0; e <= 3; e++) step(4'b1001);
      i_Rst = 1'b1;
      model_reset();
      #1;
      check_all_zero("mid_reset_zero");
      #2 i_Rst = 1'b0;
      for (int e = 0; e <= 4; e++) step(4'b1001);
      chk("mid_e4_sw", o_Switch, 4'b0000);
      step(4'b1001);
      chk("mid_e5_sw", o_Switch, 4'b1001);
      chk("mid_e5_rise", o_Rise, 4'b1001);

      // Simultaneous edges
      for (int i = 0; i < 8; i++) step(4'b0000);
      for (int e = 0; e <= 4; e++) step(4'b0101);
      step(4'b0101);
      chk("simul_rise", o_Rise, 4'b0101);
      chk("simul_sel", o_Select, 2'd0);
      step(4'b0101);
      chk("simul_rise_end", o_Rise, 4'b0000);

      // Randomized activity with mixed short (rejected) and long holds
      rv = i_Switch;
      for (int k = 0; k < NSW; k++) hold_left[k] = $urandom_range(1, 8);
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NSW; k++) begin
            hold_left[k]--;
            if (hold_left[k] <= 0) begin
               rv[k] = rv[k] ^ 1'($urandom_range(0, 1));
               hold_left[k] = $urandom_range(1, 8);
            end
         end
         step(rv);
         if (c == 200) begin
            i_Rst = 1'b1;
            model_reset();
            #1;
            check_all_zero("rand_reset_zero");
            #2 i_Rst = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/debounce_switch_bank.md
# debounce_switch_bank

Debounces a bank of raw mechanical switch inputs and produces clean levels, one-cycle edge pulses, and a derived enable/select pair. Sits directly upstream of the count-and-toggle LED blinkers and the LED output mux. o_Enable drives a blinker's enable input, which resets that blinker's toggle output whenever enable is low. o_Select picks which blinker output reaches the LED.

## Interface
- NUM_SWITCHES, default 4: number of switch channels, at least 2.
- DEBOUNCE_LIMIT, default 250000: consecutive stable cycles required before a change is accepted, at least 2. The default is 10 ms at 25 MHz.
- i_Clk, input, 1: system clock, the only clock in the block.
- i_Rst, input, 1: asynchronous, active-high reset.
- i_Switch, input, NUM_SWITCHES: raw, asynchronous, bouncing switch levels.
- o_Switch, output, NUM_SWITCHES: debounced levels; reset value all 0.
- o_Rise, output, NUM_SWITCHES: one-cycle pulse when the matching o_Switch bit goes 0->1; reset value all 0.
- o_Fall, output, NUM_SWITCHES: one-cycle pulse when the matching o_Switch bit goes 1->0; reset value all 0.
- o_Enable, output, 1: OR of all o_Switch bits; reset value 0.
- o_Select, output, $clog2(NUM_SWITCHES): index of the lowest-numbered o_Switch bit that is 1; 0 when none is set; reset value 0.

## Operation
- **Synchronizer:** each channel passes through a 2-flop synchronizer. Call the second stage s_k.
- **Counter:** each channel has an independent counter, width $clog2(DEBOUNCE_LIMIT).
- **Per-channel rules, evaluated every clock:**
  - s_k == o_Switch[k]: counter clears to 0. Any bounce therefore restarts qualification.
  - s_k != o_Switch[k] and counter < DEBOUNCE_LIMIT-1: counter increments by 1.
  - s_k != o_Switch[k] and counter == DEBOUNCE_LIMIT-1:
    - o_Switch[k] takes s_k and the counter clears.
    - The matching o_Rise[k] or o_Fall[k] is registered high for exactly that one cycle.
- **Counter range:** the counter never exceeds DEBOUNCE_LIMIT-1. No wrap-around is possible.
- **Pulse width:** o_Rise and o_Fall are 1 only in the first cycle the new o_Switch value is visible. They are 0 otherwise.
- **o_Rise/o_Fall exclusivity:** o_Rise[k] and o_Fall[k] are never high together.
- **Channel independence:** channels share no state. Simultaneous changes on several channels each qualify independently, and their pulses can coincide.
- **Derived outputs:**
  - o_Enable and o_Select are combinational from the o_Switch register, so they change in the same cycle as o_Switch.
  - o_Select uses fixed priority: bit 0 is highest.
- **Reset:** all synchronizer flops, counters, o_Switch, o_Rise and o_Fall go to 0 asynchronously.
  - A channel whose switch is held high through reset release produces a normal qualified rise afterwards.
- **Reset mid-count:** discards partial qualification. Qualification restarts from 0 after release.

## Timing
- **Edge numbering:** let edge 0 be the first i_Clk rising edge at which the new stable level is captured into synchronizer stage 1.
- **Qualification latency:** edge 1 updates s_k. Counting starts at edge 2. o_Switch[k] and the edge pulse update at edge DEBOUNCE_LIMIT+1.
  - Example: DEBOUNCE_LIMIT=4 gives an update at edge 5.
- **Pulse timing:** the pulse deasserts at edge DEBOUNCE_LIMIT+2.
- **Rejected glitches:** a glitch is rejected if the raw level returns before qualification completes. Any glitch visible at s_k for fewer than DEBOUNCE_LIMIT consecutive cycles produces no output change.
- **Output register timing:** o_Switch, o_Rise and o_Fall are registered, with no combinational path from i_Switch.
- **o_Enable/o_Select timing:** zero latency relative to o_Switch.

## Test plan
- **Reset idle:** with NUM_SWITCHES=4, DEBOUNCE_LIMIT=4, i_Switch=0, pulse i_Rst then hold 20 cycles.
  - Required: all outputs 0 throughout.
- **Clean rise:** step i_Switch[1] 0->1 and hold.
  - Required: o_Switch=4'b0010 exactly at edge 5 after capture.
  - Required: o_Rise=4'b0010 for 1 cycle, o_Enable=1, o_Select=1, o_Fall stays 0.
- **Bounce rejection:** toggle i_Switch[0] high 3 cycles, low 2, high 3, low, repeating.
  - Required: o_Switch[0] stays 0 and no pulses occur.
  - Then hold high. Required: rise at edge 5 after the final capture.
- **Priority and fall:** debounce bits 2 and 3 high, then release bit 2.
  - Required: o_Select=2 while both are high; o_Fall=4'b0100 for 1 cycle; then o_Select=3 and o_Enable stays 1.
- **Reset mid-count:** hold i_Switch[3]=1 and assert i_Rst when that channel's counter=2.
  - Required: all outputs 0 immediately.
  - After release, required: rise at edge 5 after the new capture, not earlier.
- **Simultaneous edges:** change i_Switch 4'b0000->4'b0101 on one edge.
  - Required: o_Rise=4'b0101 in a single cycle and o_Select=0.
